// File: rtl/wave_ctrl_pkg.sv
// wave_ctrl_pkg: shared types and constants for the waveform generator
// sequencing controller.
//   PHASE_W      width of the phase bus driven into the generators
//   cap_state_t  capture sequencer states
//   wave_sel_t   generator output-mux encoding
package wave_ctrl_pkg;

  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_sel_t;

endpackage

// File: rtl/wave_gen_ctrl_if.sv
// wave_gen_ctrl_if: configuration handshake and display-buffer write bus.
//   cfg_valid/cfg_ready  config offer / accept (held by offerer until accepted)
//   cfg_step/div/sel     phase increment, tick period minus 1, waveform select
//   cap_valid/addr/last  one-frame capture writes into the display buffer
// Modports: master = config source / buffer sink, slave = the controller.
interface wave_gen_ctrl_if #(
  parameter int ACC_W  = 16,
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 10
);
  import wave_ctrl_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ACC_W-1:0]  cfg_step;
  logic [DIV_W-1:0]  cfg_div;
  wave_sel_t         cfg_sel;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_last;

  modport master (
    output cfg_valid, cfg_step, cfg_div, cfg_sel,
    input  cfg_ready, cap_valid, cap_addr, cap_last
  );

  modport slave (
    input  cfg_valid, cfg_step, cfg_div, cfg_sel,
    output cfg_ready, cap_valid, cap_addr, cap_last
  );

endinterface

// File: rtl/tick_divider.sv
// tick_divider: sample-rate divider producing a registered tick once every
// div+1 cycles.
//   clk, rst  clock, async active-high reset
//   div       tick period minus 1
//   clr       restart the count as if just out of reset (used on config apply)
//   tick      sample strobe
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // After clr the divider is in its reset state, so the first tick under a
  // new div lands div+1 cycles later, same as after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_gen_ctrl.sv
// wave_gen_ctrl: sequencing controller for the waveform generator datapath.
// Runs the phase accumulator off the tick divider, applies new step/div/sel
// glitch-free at phase wrap, and captures one phase-aligned frame of
// generator output into the display buffer.
//   clk, rst  clock, async active-high reset
//   bus       config handshake + capture write bus (slave side)
//   arm       request capture of one frame
//   tick      sample strobe / clock enable for the generators
//   phase     top PHASE_W bits of the accumulator
//   wave_sel  generator output-mux select
//   busy      capture armed, running, or writes still in flight
//
// state     | meaning
// IDLE      | no capture requested; arm starts one
// WAIT_TRIG | armed, waiting for a wrap tick (sample 0)
// CAPTURE   | scheduling samples 1..FRAME_LEN-1, one per tick
module wave_gen_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int DIV_W     = 16,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 640,
  parameter int RST_STEP  = 256,
  parameter int RST_DIV   = 0
) (
  input  logic               clk,
  input  logic               rst,
  wave_gen_ctrl_if.slave     bus,
  input  logic               arm,
  output logic               tick,
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         wave_sel,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam bit                SINGLE    = (FRAME_LEN == 1);

  cap_state_t        state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_sum, step_r, pend_step;
  logic [DIV_W-1:0]  div_r, pend_div;
  wave_sel_t         sel_r, pend_sel;
  logic              pend_full;
  logic              wrap, apply;
  logic              sample, sample_last;
  logic [ADDR_W-1:0] sample_addr;
  logic              s1_valid, s1_last;
  logic [ADDR_W-1:0] s1_addr;

  tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .div  (div_r),
    .clr  (apply),
    .tick (tick)
  );

  assign {wrap, acc_sum} = {1'b0, acc} + {1'b0, step_r};
  assign phase           = acc[ACC_W-1 -: PHASE_W];
  assign wave_sel        = sel_r;
  assign bus.cfg_ready   = !pend_full;
  assign busy            = (state != IDLE) || s1_valid || bus.cap_valid;

  // With step_r == 0 a wrap can never come, so the pending slot drains on
  // any tick. Never applied mid-frame so a frame is captured with one config.
  assign apply = tick && pend_full && (state != CAPTURE) &&
                 (wrap || (step_r == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sample      = 1'b0;
    sample_addr = s1_addr;
    sample_last = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (tick && wrap) begin
          sample      = 1'b1;
          sample_addr = '0;
          sample_last = SINGLE;
          state_nxt   = SINGLE ? IDLE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (tick) begin
          sample      = 1'b1;
          sample_addr = s1_addr + ADDR_W'(1);
          sample_last = (sample_addr == LAST_ADDR);
          if (sample_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      step_r        <= ACC_W'(RST_STEP);
      div_r         <= DIV_W'(RST_DIV);
      sel_r         <= WAVE_SINE;
      pend_full     <= 1'b0;
      pend_step     <= '0;
      pend_div      <= '0;
      pend_sel      <= WAVE_SINE;
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      s1_last       <= 1'b0;
      bus.cap_valid <= 1'b0;
      bus.cap_addr  <= '0;
      bus.cap_last  <= 1'b0;
    end else begin
      if (tick) acc <= acc_sum;

      if (apply) begin
        step_r    <= pend_step;
        div_r     <= pend_div;
        sel_r     <= pend_sel;
        pend_full <= 1'b0;
      end else if (bus.cfg_valid && !pend_full) begin
        pend_full <= 1'b1;
        pend_step <= bus.cfg_step;
        pend_div  <= bus.cfg_div;
        pend_sel  <= bus.cfg_sel;
      end

      // Two-stage delay lines the write up with the generators' own
      // register stage: the sample for a tick in T is written in T+2.
      s1_valid <= sample;
      if (sample) begin
        s1_addr <= sample_addr;
        s1_last <= sample_last;
      end
      bus.cap_valid <= s1_valid;
      bus.cap_addr  <= s1_addr;
      bus.cap_last  <= s1_valid && s1_last;
    end
  end

endmodule
